// File: rtl/seq_pkg.sv
// Shared command codes, frame geometry, FSM encoding and checksum helper for the readback block.
// Build option: SEQ_READBACK_CHECKSUM_EN appends a one-byte additive checksum to each frame.
package seq_pkg;

    localparam logic [7:0] CMD_SEQ_CONFIG = 8'hF0;
    localparam logic [7:0] CMD_SEQ_QUERY  = 8'hF1;

    localparam int PAYLOAD_LEN = 13;
`ifdef SEQ_READBACK_CHECKSUM_EN
    localparam int FRAME_LEN   = PAYLOAD_LEN + 1;
`else
    localparam int FRAME_LEN   = PAYLOAD_LEN;
`endif

    localparam int BYTE_W       = 8;
    localparam int CH_W         = 3;
    localparam int LEN_W        = 7;
    localparam int CNT_W        = 4;
    localparam int FRAME_DIV_W  = 16;
    localparam int FRAME_DATA_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_LOAD = 3'd2,
`ifdef SEQ_READBACK_CHECKSUM_EN
        ST_SEND = 3'd3,
        ST_CSUM = 3'd4
`else
        ST_SEND = 3'd3
`endif
    } state_t;

    function automatic logic [7:0] payload_sum(input logic [PAYLOAD_LEN*BYTE_W-1:0] payload);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            acc = acc + payload[BYTE_W*i +: BYTE_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/seq_shadow_regs.sv
// Per-channel shadow copy of the sequencer configuration bus, cleared by reset,
// written by the config strobe and read combinationally by channel index.
module seq_shadow_regs
    import seq_pkg::*;
#(
    parameter int NUM_CHANNELS  = 8,
    parameter int DIVIDER_WIDTH = 16,
    parameter int SEQ_MAX_BITS  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [CH_W-1:0]          i_wr_ch,
    input  logic                     i_wr_enable,
    input  logic [DIVIDER_WIDTH-1:0] i_wr_div,
    input  logic [LEN_W-1:0]         i_wr_len,
    input  logic [SEQ_MAX_BITS-1:0]  i_wr_data,
    input  logic [CH_W-1:0]          i_rd_ch,
    output logic                     o_rd_enable,
    output logic [DIVIDER_WIDTH-1:0] o_rd_div,
    output logic [LEN_W-1:0]         o_rd_len,
    output logic [SEQ_MAX_BITS-1:0]  o_rd_data
);

    typedef struct packed {
        logic                     enable;
        logic [DIVIDER_WIDTH-1:0] div;
        logic [LEN_W-1:0]         len;
        logic [SEQ_MAX_BITS-1:0]  data;
    } entry_t;

    entry_t w_wr_entry;
    entry_t w_rd_entry;
    entry_t w_entries [NUM_CHANNELS];

    assign w_wr_entry = {i_wr_enable, i_wr_div, i_wr_len, i_wr_data};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_entry
            entry_t r_entry;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_entry <= '0;
                end else if (i_wr_en && (i_wr_ch == CH_W'(gi))) begin
                    r_entry <= w_wr_entry;
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    // Channels beyond NUM_CHANNELS read back as all-zero.
    always_comb begin
        w_rd_entry = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (i_rd_ch == CH_W'(i)) begin
                w_rd_entry = w_entries[i];
            end
        end
    end

    assign o_rd_enable = w_rd_entry.enable;
    assign o_rd_div    = w_rd_entry.div;
    assign o_rd_len    = w_rd_entry.len;
    assign o_rd_data   = w_rd_entry.data;

endmodule

// File: rtl/seq_readback_handler.sv
// SEQ_QUERY handler: latches a channel from the command payload and streams that channel's
// shadow configuration as a 13-byte upload frame (14 with SEQ_READBACK_CHECKSUM_EN defined).
module seq_readback_handler
    import seq_pkg::*;
#(
    parameter int         NUM_CHANNELS  = 8,
    parameter int         DIVIDER_WIDTH = 16,
    parameter int         SEQ_MAX_BITS  = 64,
    parameter logic [7:0] CMD_CODE      = CMD_SEQ_QUERY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               cmd_type,
    input  logic [15:0]              cmd_length,
    input  logic [7:0]               cmd_data,
    input  logic [15:0]              cmd_data_index,
    input  logic                     cmd_start,
    input  logic                     cmd_data_valid,
    input  logic                     cmd_done,
    output logic                     cmd_ready,
    input  logic [2:0]               config_ch_index,
    input  logic                     config_enable,
    input  logic [DIVIDER_WIDTH-1:0] config_freq_div,
    input  logic [6:0]               config_seq_len,
    input  logic [SEQ_MAX_BITS-1:0]  config_seq_data,
    input  logic                     config_update_strobe,
    output logic                     upload_req,
    output logic [7:0]               upload_source,
    output logic [7:0]               upload_data,
    output logic                     upload_valid,
    input  logic                     upload_ready
);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [CH_W-1:0]            r_query_ch;
    logic [CNT_W-1:0]           r_byte_cnt;
    logic [BYTE_W-1:0]          r_frame [FRAME_LEN];

    logic                       w_rd_enable;
    logic [DIVIDER_WIDTH-1:0]   w_rd_div;
    logic [LEN_W-1:0]           w_rd_len;
    logic [SEQ_MAX_BITS-1:0]    w_rd_data;
    logic [FRAME_DIV_W-1:0]     w_div16;
    logic [FRAME_DATA_W-1:0]    w_data64;
    logic [PAYLOAD_LEN*BYTE_W-1:0] w_payload;
    logic                       w_sending;
    logic                       w_accept;
    logic                       w_last_payload;
    logic                       w_unused;

    assign w_unused = ^{cmd_length, cmd_data[BYTE_W-1:CH_W]};

    seq_shadow_regs #(
        .NUM_CHANNELS  (NUM_CHANNELS),
        .DIVIDER_WIDTH (DIVIDER_WIDTH),
        .SEQ_MAX_BITS  (SEQ_MAX_BITS)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (config_update_strobe),
        .i_wr_ch     (config_ch_index),
        .i_wr_enable (config_enable),
        .i_wr_div    (config_freq_div),
        .i_wr_len    (config_seq_len),
        .i_wr_data   (config_seq_data),
        .i_rd_ch     (r_query_ch),
        .o_rd_enable (w_rd_enable),
        .o_rd_div    (w_rd_div),
        .o_rd_len    (w_rd_len),
        .o_rd_data   (w_rd_data)
    );

    // The frame format is fixed at 16 divider bits and 64 pattern bits regardless of parameters.
    generate
        if (DIVIDER_WIDTH >= FRAME_DIV_W) begin : g_div_trunc
            assign w_div16 = w_rd_div[FRAME_DIV_W-1:0];
        end else begin : g_div_ext
            assign w_div16 = {{(FRAME_DIV_W-DIVIDER_WIDTH){1'b0}}, w_rd_div};
        end
        if (SEQ_MAX_BITS >= FRAME_DATA_W) begin : g_data_trunc
            assign w_data64 = w_rd_data[FRAME_DATA_W-1:0];
        end else begin : g_data_ext
            assign w_data64 = {{(FRAME_DATA_W-SEQ_MAX_BITS){1'b0}}, w_rd_data};
        end
    endgenerate

    // Byte k of the frame lives at w_payload[8k +: 8].
    always_comb begin
        w_payload            = '0;
        w_payload[0 +: 8]    = {{(BYTE_W-CH_W){1'b0}}, r_query_ch};
        w_payload[8 +: 8]    = {7'b0, w_rd_enable};
        w_payload[16 +: 8]   = w_div16[15:8];
        w_payload[24 +: 8]   = w_div16[7:0];
        w_payload[32 +: 8]   = {1'b0, w_rd_len};
        w_payload[40 +: 64]  = w_data64;
    end

`ifdef SEQ_READBACK_CHECKSUM_EN
    assign w_sending = (r_state == ST_SEND) || (r_state == ST_CSUM);
`else
    assign w_sending = (r_state == ST_SEND);
`endif
    assign w_accept       = w_sending && upload_ready;
    assign w_last_payload = (r_byte_cnt == CNT_W'(PAYLOAD_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        upload_req   = 1'b0;
        upload_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_start && (cmd_type == CMD_CODE)) begin
                    w_state_next = ST_RECV;
                end
            end
            ST_RECV: begin
                cmd_ready = 1'b1;
                if (cmd_done) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_next = ST_SEND;
            end
            ST_SEND: begin
                upload_req   = 1'b1;
                upload_valid = 1'b1;
                if (upload_ready && w_last_payload) begin
`ifdef SEQ_READBACK_CHECKSUM_EN
                    w_state_next = ST_CSUM;
`else
                    w_state_next = ST_IDLE;
`endif
                end
            end
`ifdef SEQ_READBACK_CHECKSUM_EN
            ST_CSUM: begin
                upload_req   = 1'b1;
                upload_valid = 1'b1;
                if (upload_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_query_ch <= '0;
            r_byte_cnt <= '0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_frame[i] <= '0;
            end
        end else begin
            case (r_state)
                // A query that never delivers byte 0 must read channel 0, not a stale channel.
                ST_IDLE: r_query_ch <= '0;
                ST_RECV: begin
                    if (cmd_data_valid && (cmd_data_index == 16'd0)) begin
                        r_query_ch <= cmd_data[CH_W-1:0];
                    end
                end
                ST_LOAD: begin
                    r_byte_cnt <= '0;
                    for (int i = 0; i < PAYLOAD_LEN; i++) begin
                        r_frame[i] <= w_payload[BYTE_W*i +: BYTE_W];
                    end
`ifdef SEQ_READBACK_CHECKSUM_EN
                    r_frame[PAYLOAD_LEN] <= payload_sum(w_payload);
`endif
                end
                default: begin
                    if (w_accept && (r_byte_cnt != CNT_W'(FRAME_LEN - 1))) begin
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign upload_data   = upload_valid ? r_frame[r_byte_cnt] : '0;
    assign upload_source = upload_req ? CMD_CODE : '0;

endmodule

// File: tb/tb_seq_readback_handler.sv
// Bench for seq_readback_handler: table of spec frames, hand-built corner sequences and
// randomized config/query traffic checked against a channel-table model.
module tb_seq_readback_handler;

`ifdef SEQ_READBACK_CHECKSUM_EN
    localparam int TB_FRAME_LEN = 14;
`else
    localparam int TB_FRAME_LEN = 13;
`endif
    localparam logic [7:0] Q_CODE = 8'hF1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_data_index;
    logic        cmd_start;
    logic        cmd_data_valid;
    logic        cmd_done;
    logic        cmd_ready;
    logic [2:0]  config_ch_index;
    logic        config_enable;
    logic [15:0] config_freq_div;
    logic [6:0]  config_seq_len;
    logic [63:0] config_seq_data;
    logic        config_update_strobe;
    logic        upload_req;
    logic [7:0]  upload_source;
    logic [7:0]  upload_data;
    logic        upload_valid;
    logic        upload_ready;

    seq_readback_handler dut (
        .clk                  (clk),
        .rst                  (rst),
        .cmd_type             (cmd_type),
        .cmd_length           (cmd_length),
        .cmd_data             (cmd_data),
        .cmd_data_index       (cmd_data_index),
        .cmd_start            (cmd_start),
        .cmd_data_valid       (cmd_data_valid),
        .cmd_done             (cmd_done),
        .cmd_ready            (cmd_ready),
        .config_ch_index      (config_ch_index),
        .config_enable        (config_enable),
        .config_freq_div      (config_freq_div),
        .config_seq_len       (config_seq_len),
        .config_seq_data      (config_seq_data),
        .config_update_strobe (config_update_strobe),
        .upload_req           (upload_req),
        .upload_source        (upload_source),
        .upload_data          (upload_data),
        .upload_valid         (upload_valid),
        .upload_ready         (upload_ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the shadow table should hold.
    logic        m_en   [8];
    logic [15:0] m_div  [8];
    logic [6:0]  m_len  [8];
    logic [63:0] m_data [8];

    // Values used when a strobe is injected in the LOAD cycle.
    logic [2:0]  g_ch;
    logic        g_en;
    logic [15:0] g_div;
    logic [6:0]  g_len;
    logic [63:0] g_data;

    typedef struct {
        bit           do_cfg;
        logic [2:0]   cfg_ch;
        logic         cfg_en;
        logic [15:0]  cfg_div;
        logic [6:0]   cfg_len;
        logic [63:0]  cfg_data;
        logic [2:0]   q_ch;
        int           mode;
        logic [103:0] exp_frame;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_en[i] = 1'b0; m_div[i] = '0; m_len[i] = '0; m_data[i] = '0;
        end
    endtask

    function automatic void model_frame(input logic [2:0] ch, output logic [7:0] f [14]);
        logic [7:0] sum;
        f[0] = {5'b0, ch};
        f[1] = {7'b0, m_en[ch]};
        f[2] = m_div[ch] >> 8;
        f[3] = m_div[ch][7:0];
        f[4] = {1'b0, m_len[ch]};
        for (int k = 0; k < 8; k++) f[5 + k] = 8'(m_data[ch] >> (8 * k));
        sum = 8'd0;
        for (int i = 0; i < 13; i++) sum = sum + f[i];
        f[13] = sum;
    endfunction

    task automatic cfg_write(input logic [2:0] ch, input logic en, input logic [15:0] dv,
                             input logic [6:0] ln, input logic [63:0] dt);
        config_ch_index = ch; config_enable = en; config_freq_div = dv;
        config_seq_len = ln; config_seq_data = dt; config_update_strobe = 1'b1;
        @(negedge clk);
        config_update_strobe = 1'b0;
        m_en[ch] = en; m_div[ch] = dv; m_len[ch] = ln; m_data[ch] = dt;
    endtask

    // Leaves cmd_done high at a negedge; collect() lowers it.
    task automatic issue_query(input logic [7:0] typ, input logic [2:0] ch, input bit send0, input bit extra);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_type = typ; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        if (send0) begin
            cmd_data_valid = 1'b1; cmd_data_index = 16'd0; cmd_data = {5'($urandom), ch};
            @(negedge clk);
        end
        if (extra) begin
            cmd_data_valid = 1'b1; cmd_data_index = 16'($urandom_range(1, 12)); cmd_data = 8'($urandom);
            @(negedge clk);
        end
        cmd_data_valid = 1'b0; cmd_done = 1'b1;
    endtask

    task automatic collect(input logic [7:0] exp [14], input int mode, input int stop_after, input bit load_strobe);
        int         idx;
        int         cyc;
        bit         held;
        bit         tog;
        bit         rdy;
        logic [7:0] held_data;
        idx = 0; cyc = 0; held = 1'b0; tog = 1'b1; held_data = '0;
        @(negedge clk);
        cmd_done = 1'b0;
        check("load_cycle_valid", 64'(upload_valid), 64'd0);
        if (load_strobe) begin
            config_ch_index = g_ch; config_enable = g_en; config_freq_div = g_div;
            config_seq_len = g_len; config_seq_data = g_data; config_update_strobe = 1'b1;
        end
        @(negedge clk);
        if (load_strobe) begin
            config_update_strobe = 1'b0;
            m_en[g_ch] = g_en; m_div[g_ch] = g_div; m_len[g_ch] = g_len; m_data[g_ch] = g_data;
        end
        check("first_valid_latency", 64'(upload_valid), 64'd1);
        while (idx < TB_FRAME_LEN) begin
            if (cyc > 400) begin
                n_checks++; n_errors++;
                $display("FAIL frame_timeout: got %0d bytes, expected %0d", idx, TB_FRAME_LEN);
                break;
            end
            if (!upload_valid) begin
                check($sformatf("frame_gap_at_byte%0d", idx), 64'(upload_valid), 64'd1);
                break;
            end
            if (held) check($sformatf("hold_byte%0d", idx), 64'(upload_data), 64'(held_data));
            case (mode)
                0:       rdy = 1'b1;
                1:       begin rdy = tog; tog = !tog; end
                default: rdy = ($urandom_range(0, 99) < 70);
            endcase
            upload_ready = rdy;
            if (rdy) begin
                check($sformatf("frame_byte%0d", idx), 64'(upload_data), 64'(exp[idx]));
                check("upload_source", 64'(upload_source), 64'(Q_CODE));
                check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
                idx++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                held_data = upload_data;
            end
            @(negedge clk);
            cyc++;
            if (stop_after > 0 && idx == stop_after) begin
                upload_ready = 1'b1;
                return;
            end
        end
        upload_ready = 1'b1;
        check("end_upload_valid", 64'(upload_valid), 64'd0);
        check("end_upload_req", 64'(upload_req), 64'd0);
        $display("frame ch=%0d bytes=%0d cycles=%0d mode=%0d", exp[0], idx, cyc, mode);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   f [14];
        logic [103:0] ef;
        logic [7:0]   sum;
        int           seen;
        int           ready_low;

        rst = 1'b1; cmd_type = 8'h00; cmd_length = 16'd13; cmd_data = 8'h00; cmd_data_index = 16'd0;
        cmd_start = 1'b0; cmd_data_valid = 1'b0; cmd_done = 1'b0;
        config_ch_index = 3'd0; config_enable = 1'b0; config_freq_div = '0; config_seq_len = '0;
        config_seq_data = '0; config_update_strobe = 1'b0; upload_ready = 1'b1;
        g_ch = '0; g_en = 1'b0; g_div = '0; g_len = '0; g_data = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_upload_req", 64'(upload_req), 64'd0);
        check("rst_upload_valid", 64'(upload_valid), 64'd0);
        check("rst_upload_data", 64'(upload_data), 64'd0);
        check("rst_upload_source", 64'(upload_source), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        vecs[0] = '{do_cfg: 0, cfg_ch: 0, cfg_en: 0, cfg_div: 0, cfg_len: 0, cfg_data: 0, q_ch: 3, mode: 0,
                    exp_frame: 104'h0300_0000_0000_0000_0000_0000_00};
        vecs[1] = '{do_cfg: 1, cfg_ch: 0, cfg_en: 1, cfg_div: 16'd60, cfg_len: 7'd10, cfg_data: 64'h155, q_ch: 0, mode: 0,
                    exp_frame: 104'h0001_003C_0A55_0100_0000_0000_00};
        vecs[2] = '{do_cfg: 0, cfg_ch: 0, cfg_en: 0, cfg_div: 0, cfg_len: 0, cfg_data: 0, q_ch: 0, mode: 1,
                    exp_frame: 104'h0001_003C_0A55_0100_0000_0000_00};
        vecs[3] = '{do_cfg: 1, cfg_ch: 5, cfg_en: 0, cfg_div: 16'hABCD, cfg_len: 7'h7F,
                    cfg_data: 64'h0123_4567_89AB_CDEF, q_ch: 5, mode: 2,
                    exp_frame: 104'h0500_ABCD_7FEF_CDAB_8967_4523_01};

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].do_cfg) begin
                cfg_write(vecs[v].cfg_ch, vecs[v].cfg_en, vecs[v].cfg_div, vecs[v].cfg_len, vecs[v].cfg_data);
            end
            ef = vecs[v].exp_frame;
            sum = 8'd0;
            for (int i = 0; i < 13; i++) begin
                f[i] = ef[8 * (12 - i) +: 8];
                sum = sum + f[i];
            end
            f[13] = sum;
            issue_query(Q_CODE, vecs[v].q_ch, 1'b1, 1'b0);
            collect(f, vecs[v].mode, 0, 1'b0);
        end

        // No byte 0, only a nonzero index: channel must default to 0.
        model_frame(3'd0, f);
        issue_query(Q_CODE, 3'd6, 1'b0, 1'b1);
        collect(f, 0, 0, 1'b0);

        // Byte 0 followed by a nonzero index that must be ignored.
        model_frame(3'd5, f);
        issue_query(Q_CODE, 3'd5, 1'b1, 1'b1);
        collect(f, 2, 0, 1'b0);

        // Strobe in the LOAD cycle: frame carries the pre-write entry.
        g_ch = 3'd5; g_en = 1'b1; g_div = 16'h0F0F; g_len = 7'h22; g_data = 64'hDEAD_BEEF_0000_1111;
        model_frame(3'd5, f);
        issue_query(Q_CODE, 3'd5, 1'b1, 1'b0);
        collect(f, 0, 0, 1'b1);
        model_frame(3'd5, f);
        issue_query(Q_CODE, 3'd5, 1'b1, 1'b0);
        collect(f, 0, 0, 1'b0);

        // Strobe during SEND must not alter the frame in flight; next query sees it.
        model_frame(3'd0, f);
        issue_query(Q_CODE, 3'd0, 1'b1, 1'b0);
        fork
            collect(f, 1, 0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                cfg_write(3'd0, m_en[0], 16'h1234, m_len[0], m_data[0]);
            end
        join
        model_frame(3'd0, f);
        issue_query(Q_CODE, 3'd0, 1'b1, 1'b0);
        collect(f, 0, 0, 1'b0);

        // SEQ_CONFIG command must not produce a frame.
        issue_query(8'hF0, 3'd2, 1'b1, 1'b0);
        @(negedge clk);
        cmd_done = 1'b0;
        seen = 0; ready_low = 0;
        repeat (10) begin
            if (upload_valid || upload_req) seen++;
            if (!cmd_ready) ready_low++;
            @(negedge clk);
        end
        check("cfg_cmd_no_frame", 64'(seen), 64'd0);
        check("cfg_cmd_ready_held", 64'(ready_low), 64'd0);

        // A new query arriving during SEND is ignored entirely.
        model_frame(3'd2, f);
        issue_query(Q_CODE, 3'd2, 1'b1, 1'b0);
        fork
            collect(f, 0, 0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                cmd_type = Q_CODE; cmd_start = 1'b1; cmd_data_valid = 1'b1;
                cmd_data_index = 16'd0; cmd_data = 8'h07;
                @(negedge clk);
                cmd_start = 1'b0; cmd_data_valid = 1'b0; cmd_done = 1'b1;
                @(negedge clk);
                cmd_done = 1'b0;
            end
        join
        seen = 0;
        repeat (10) begin
            if (upload_valid || upload_req) seen++;
            @(negedge clk);
        end
        check("busy_query_no_frame", 64'(seen), 64'd0);

        // Reset after byte 5 accepted aborts immediately; fresh query starts from byte 0.
        model_frame(3'd0, f);
        issue_query(Q_CODE, 3'd0, 1'b1, 1'b0);
        collect(f, 0, 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_upload_req", 64'(upload_req), 64'd0);
        check("abort_upload_valid", 64'(upload_valid), 64'd0);
        check("abort_upload_data", 64'(upload_data), 64'd0);
        check("abort_upload_source", 64'(upload_source), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        $display("reset abort after 5 bytes");
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        model_frame(3'd0, f);
        issue_query(Q_CODE, 3'd0, 1'b1, 1'b0);
        collect(f, 0, 0, 1'b0);

        // Randomized config traffic and queries against the model.
        for (int it = 0; it < 40; it++) begin
            int          nw;
            logic [2:0]  ch;
            bit          s0;
            bit          ex;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                cfg_write(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                          7'($urandom_range(0, 127)), {$urandom, $urandom});
            end
            ch = 3'($urandom_range(0, 7));
            s0 = ($urandom_range(0, 3) != 0);
            ex = 1'($urandom_range(0, 1));
            model_frame(s0 ? ch : 3'd0, f);
            issue_query(Q_CODE, ch, s0, ex);
            collect(f, $urandom_range(0, 2), 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
